// File: rtl/jtag_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : jtag_seq_ctrl
// Purpose : Command-driven JTAG master; walks the TAP FSM with TMS/TDI and
//           returns the TDO bits captured during IR/DR shifts.
// Revision: 1.0 - initial release
// ============================================================================
module jtag_seq_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tap_tms,
  output logic               tap_tdi,
  input  logic               tap_tdo
);

  localparam logic [1:0] CMD_RESET    = 2'd0;
  localparam logic [1:0] CMD_SHIFT_IR = 2'd1;
  localparam logic [1:0] CMD_SHIFT_DR = 2'd2;
  localparam logic [1:0] CMD_IDLE     = 2'd3;
  // Counter must also cover the fixed 6/7-cycle reset and init sequences
  localparam int         CNT_W        = (LEN_W > 3) ? LEN_W : 3;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_HDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_POST  = 3'd4,
    S_RUN   = 3'd5,
    S_RSP   = 3'd6
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d, clen;
  logic [1:0]         ctype;
  logic [MAX_LEN-1:0] sreg, bit_sel, cap_mask;
  logic               tms_d, tdi_d, accept, shift_en, hdr_last;
  logic               is_shift, len_zero, len_over;
  logic [LEN_W-1:0]   len_eff;

  assign is_shift = (cmd_type == CMD_SHIFT_IR) || (cmd_type == CMD_SHIFT_DR);
  assign len_zero = (cmd_len == '0);
  assign len_over = (cmd_len > LEN_W'(MAX_LEN));
  assign len_eff  = (is_shift && len_over) ? LEN_W'(MAX_LEN) : cmd_len;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + CNT_ONE;
    tms_d    = 1'b0;
    tdi_d    = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
    hdr_last = 1'b0;
    case (state)
      S_INIT: begin
        tms_d = (cnt < CNT_W'(5));
        if (cnt == CNT_W'(6)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          if (cmd_type == CMD_IDLE) begin
            state_d = len_zero ? S_RSP : S_RUN;
          end else if (is_shift && len_zero) begin
            state_d = S_RSP;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        case (ctype)
          CMD_RESET: begin
            tms_d    = (cnt != CNT_W'(5));
            hdr_last = (cnt == CNT_W'(5));
          end
          CMD_SHIFT_IR: begin
            tms_d    = (cnt < CNT_W'(2));
            hdr_last = (cnt == CNT_W'(3));
          end
          default: begin
            tms_d    = (cnt == '0);
            hdr_last = (cnt == CNT_W'(2));
          end
        endcase
        if (hdr_last) begin
          state_d = (ctype == CMD_RESET) ? S_RSP : S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        tdi_d    = sreg[0];
        // Last bit carries TMS=1 so the TAP leaves SHIFT for EXIT_1
        tms_d    = (cnt == clen - CNT_ONE);
        if (tms_d) begin
          state_d = S_POST;
          cnt_d   = '0;
        end
      end
      S_POST: begin
        tms_d = (cnt == '0);
        if (cnt == CNT_ONE) begin
          state_d = S_RSP;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt == clen - CNT_ONE) begin
          state_d = S_RSP;
          cnt_d   = '0;
        end
      end
      S_RSP: begin
        cnt_d = '0;
        if (rsp_valid && rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state     <= S_INIT;
      cnt       <= '0;
      tap_tms   <= 1'b1;
      tap_tdi   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b1;
      ctype     <= CMD_RESET;
      clen      <= '0;
      sreg      <= '0;
      bit_sel   <= '0;
      cap_mask  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      tap_tms   <= tms_d;
      tap_tdi   <= tdi_d;
      cmd_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      rsp_valid <= (state == S_RSP) && !(rsp_valid && rsp_ready);
      cap_mask  <= '0;
      // TDO for bit i is sampled one edge after bit i was driven
      rsp_data  <= rsp_data | (cap_mask & {MAX_LEN{tap_tdo}});
      if (accept) begin
        ctype    <= cmd_type;
        clen     <= CNT_W'(len_eff);
        sreg     <= cmd_data;
        bit_sel  <= MAX_LEN'(1);
        rsp_data <= '0;
        rsp_err  <= is_shift && (len_zero || len_over);
      end
      if (shift_en) begin
        sreg     <= sreg >> 1;
        bit_sel  <= bit_sel << 1;
        cap_mask <= bit_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_seq_ctrl.sv
`default_nettype none
// Bench for jtag_seq_ctrl: directed vector table, reset sequences and random
// commands checked against a bit-stream model of the TAP walk.
module tb_jtag_seq_ctrl;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               TCK = 1'b0;
  logic               TRST = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = 2'd0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               tap_tms;
  logic               tap_tdi;
  logic               tap_tdo = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit loopback = 1'b1;

  jtag_seq_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .TCK(TCK), .TRST(TRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .tap_tms(tap_tms), .tap_tdi(tap_tdi), .tap_tdo(tap_tdo)
  );

  always #5 TCK = ~TCK;

  // TAP stand-in: TDO changes on the falling edge, either echoing TDI or random
  always @(negedge TCK) tap_tdo = loopback ? tap_tdi : 1'($urandom);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic reset_seq(input string tag);
    logic [7:0] tms_tr, rdy_tr, rv_tr;
    TRST = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    check({tag, "_reset_values"},
          {tap_tms, tap_tdi, cmd_ready, rsp_valid, rsp_err, busy, |rsp_data}, 7'b1000010);
    repeat (2) @(posedge TCK);
    @(negedge TCK);
    TRST = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge TCK); #1;
      tms_tr[e] = tap_tms; rdy_tr[e] = cmd_ready; rv_tr[e] = rsp_valid;
    end
    check({tag, "_init_tms"}, tms_tr, 8'b0001_1111);
    check({tag, "_init_ready"}, rdy_tr, 8'b1100_0000);
    check({tag, "_init_rsp_valid"}, rv_tr, 8'b0000_0000);
  endtask

  task automatic exec_cmd(input logic [1:0] t, input int len, input logic [31:0] d,
                          input int hold, input bit press,
                          output int lat, output logic [31:0] rdat, output logic rerr);
    logic [127:0] tms_tr, tdi_tr, tdo_tr, exp_tms, exp_tdi;
    logic [31:0]  exp_d;
    bit           q[$];
    bit           shift_cmd, exp_err, stable_ok;
    int           eff, hdr, w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin @(posedge TCK); #1; w++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_type = t; cmd_len = LEN_W'(len); cmd_data = d; cmd_valid = 1'b1;
    @(posedge TCK); #1;
    cmd_valid = 1'b0; cmd_type = 2'($urandom); cmd_len = LEN_W'($urandom); cmd_data = $urandom;
    check("accept", {cmd_ready, busy, rsp_valid}, 3'b010);
    tms_tr = '0; tdi_tr = '0; tdo_tr = '0; lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge TCK); #1;
      tms_tr[e] = tap_tms; tdi_tr[e] = tap_tdi; tdo_tr[e] = tap_tdo;
      if (rsp_valid === 1'b1) begin lat = e; break; end
    end
    rdat = rsp_data; rerr = rsp_err;

    // Reference: the TMS stream the TAP walk needs, one entry per TCK edge
    shift_cmd = (t == 2'd1) || (t == 2'd2);
    eff       = (shift_cmd && len > MAX_LEN) ? MAX_LEN : len;
    exp_err   = shift_cmd && (len == 0 || len > MAX_LEN);
    hdr       = (t == 2'd2) ? 3 : (t == 2'd1) ? 4 : 0;
    exp_tdi   = '0; exp_d = '0; q.delete();
    if (t == 2'd0) begin
      q = '{1, 1, 1, 1, 1, 0};
    end else if (t == 2'd3) begin
      for (int i = 0; i < eff; i++) q.push_back(1'b0);
    end else if (eff > 0) begin
      q.push_back(1'b1);
      if (t == 2'd1) q.push_back(1'b1);
      q.push_back(1'b0); q.push_back(1'b0);
      for (int i = 0; i < eff; i++) begin
        q.push_back(i == eff - 1);
        exp_tdi[hdr + 1 + i] = d[i];
        exp_d[i] = tdo_tr[hdr + 2 + i];
      end
      q.push_back(1'b1); q.push_back(1'b0);
    end
    exp_tms = '0;
    foreach (q[j]) exp_tms[j + 1] = q[j];
    check("latency", lat, q.size() + 1);
    check("tms_seq", tms_tr, exp_tms);
    check("tdi_seq", tdi_tr, exp_tdi);
    check("rsp_data", rdat, exp_d);
    check("rsp_err", rerr, exp_err);

    stable_ok = 1'b1;
    if (press) begin cmd_valid = 1'b1; cmd_type = 2'd3; cmd_len = LEN_W'(1); end
    for (int h = 0; h < hold; h++) begin
      @(posedge TCK); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== rdat || rsp_err !== rerr ||
          tap_tms !== 1'b0 || tap_tdi !== 1'b0 || cmd_ready !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) check("rsp_hold", stable_ok, 1);
    rsp_ready = 1'b1;
    @(posedge TCK); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check("rsp_done", {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic [1:0]  t;
    int          len;
    logic [31:0] d;
    bit          loop;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        tbl[10];
  int          lat;
  logic [31:0] rdat;
  logic        rerr;
  logic [31:0] d6;

  initial begin
    tbl[0] = '{t:2'd1, len:4,  d:32'h5,        loop:1'b1, exp_lat:11, exp_err:1'b0, exp_data:32'h5};
    tbl[1] = '{t:2'd2, len:8,  d:32'hA5,       loop:1'b1, exp_lat:14, exp_err:1'b0, exp_data:32'hA5};
    tbl[2] = '{t:2'd0, len:9,  d:32'hFFFF,     loop:1'b1, exp_lat:7,  exp_err:1'b0, exp_data:32'h0};
    tbl[3] = '{t:2'd3, len:5,  d:32'h0,        loop:1'b1, exp_lat:6,  exp_err:1'b0, exp_data:32'h0};
    tbl[4] = '{t:2'd3, len:0,  d:32'h0,        loop:1'b1, exp_lat:1,  exp_err:1'b0, exp_data:32'h0};
    tbl[5] = '{t:2'd2, len:0,  d:32'hFFFFFFFF, loop:1'b1, exp_lat:1,  exp_err:1'b1, exp_data:32'h0};
    tbl[6] = '{t:2'd2, len:37, d:32'hDEADBEEF, loop:1'b1, exp_lat:38, exp_err:1'b1, exp_data:32'hDEADBEEF};
    tbl[7] = '{t:2'd1, len:32, d:32'h12345678, loop:1'b1, exp_lat:39, exp_err:1'b0, exp_data:32'h12345678};
    tbl[8] = '{t:2'd2, len:1,  d:32'h1,        loop:1'b1, exp_lat:7,  exp_err:1'b0, exp_data:32'h1};
    tbl[9] = '{t:2'd1, len:0,  d:32'hF,        loop:1'b1, exp_lat:1,  exp_err:1'b1, exp_data:32'h0};

    #3;
    reset_seq("t1");

    for (int v = 0; v < 10; v++) begin
      loopback = tbl[v].loop;
      exec_cmd(tbl[v].t, tbl[v].len, tbl[v].d, 1, 1'b0, lat, rdat, rerr);
      check($sformatf("vec%0d_latency", v), lat, tbl[v].exp_lat);
      check($sformatf("vec%0d_err", v), rerr, tbl[v].exp_err);
      check($sformatf("vec%0d_data", v), rdat, tbl[v].exp_data);
    end

    // Response back-pressure with a competing command held valid
    loopback = 1'b1;
    exec_cmd(2'd2, 8, 32'hA5, 10, 1'b1, lat, rdat, rerr);
    check("t4_data", rdat, 32'hA5);

    // Reset in the middle of a DR shift (bit 3 is driven at edge 7)
    d6 = $urandom;
    cmd_type = 2'd2; cmd_len = LEN_W'(16); cmd_data = d6; cmd_valid = 1'b1;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge TCK);
    #1;
    check("t6_mid_shift", {busy, tap_tdi, rsp_valid}, {1'b1, d6[3], 1'b0});
    reset_seq("t6");

    for (int r = 0; r < 40; r++) begin
      logic [1:0] t;
      int         len;
      t        = 2'($urandom_range(0, 3));
      len      = (t == 2'd3) ? int'($urandom_range(0, MAX_LEN)) : int'($urandom_range(0, MAX_LEN + 8));
      loopback = 1'($urandom_range(0, 1));
      exec_cmd(t, len, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               lat, rdat, rerr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
